// File: rtl/sgmii_rx_decode.sv
// SGMII receive decoder: parses TBI ordered sets, runs a reduced SGMII
// autonegotiation state machine and turns /S/ /T/ /E/ framing into GMII
// receive signals once the link is up.
module sgmii_rx_decode #(
  parameter int MATCH_COUNT = 3,
  parameter int IDLE_COUNT  = 8
) (
  input  logic        clk_125mhz,
  input  logic        rst,
  input  logic        rx_sync,
  input  logic [7:0]  rx_byte,
  input  logic        rx_is_k,
  input  logic        rx_err,
  output logic [7:0]  gmii_rxd,
  output logic        gmii_rx_dv,
  output logic        gmii_rx_err,
  output logic        sgmii_autoneg_start,
  output logic        sgmii_autoneg_ack,
  output logic        sgmii_autoneg_done,
  output logic [15:0] partner_config,
  output logic        config_valid
);

  localparam logic [7:0] K28_5   = 8'hBC;
  localparam logic [7:0] K_S     = 8'hFB;
  localparam logic [7:0] K_T     = 8'hFD;
  localparam logic [7:0] K_E     = 8'hFE;
  localparam logic [7:0] MATCH_N = 8'(MATCH_COUNT);
  localparam logic [7:0] IDLE_N  = 8'(IDLE_COUNT);
  localparam logic [7:0] ZERO_N  = 8'd3;

  typedef enum logic [2:0] {
    DISABLED, ABILITY_DETECT, ACK_DETECT, LINK_WAIT, LINK_OK
  } an_state_t;

  an_state_t   state, state_nx;
  logic [1:0]  pos;
  logic [7:0]  word_lo;
  logic [15:0] prev_word;
  logic [7:0]  match_cnt, idle_cnt, cfg_run, zero_run, ack_cnt;
  logic [7:0]  match_nx, idle_nx, cfg_nx, zero_nx, ack_nx;
  logic        start_seen, in_frame, latch_cfg;
  logic        is_comma, set_abort, idle_done, word_done;
  logic [15:0] word_cur;
  logic        word_eq_prev, word_eq_partner;
  logic [7:0]  rxd_p1;
  logic        vld_p1, err_p1;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

  function automatic logic [15:0] mask_ack(input logic [15:0] v);
    return v & 16'hBFFF;
  endfunction

  assign gmii_rxd    = rxd_p1;
  assign gmii_rx_dv  = vld_p1;
  assign gmii_rx_err = err_p1;

  // Ordered-set decode of the current byte and next counter values
  always_comb begin
    is_comma        = rx_is_k && !rx_err && (rx_byte == K28_5);
    set_abort       = rx_sync && (pos != 2'd0) && !is_comma && (rx_is_k || rx_err);
    idle_done       = rx_sync && (pos == 2'd1) && !rx_is_k && !rx_err &&
                      ((rx_byte == 8'hC5) || (rx_byte == 8'h50));
    word_done       = rx_sync && (pos == 2'd3) && !rx_is_k && !rx_err;
    word_cur        = {rx_byte, word_lo};
    word_eq_prev    = (mask_ack(word_cur) == mask_ack(prev_word));
    word_eq_partner = (mask_ack(word_cur) == mask_ack(partner_config));
    match_nx = match_cnt;
    idle_nx  = idle_cnt;
    cfg_nx   = cfg_run;
    zero_nx  = zero_run;
    if (set_abort) begin
      match_nx = 8'd0;
      idle_nx  = 8'd0;
      cfg_nx   = 8'd0;
      zero_nx  = 8'd0;
    end else if (idle_done) begin
      idle_nx = sat_inc(idle_cnt, IDLE_N);
      cfg_nx  = 8'd0;
      zero_nx = 8'd0;
    end else if (word_done) begin
      match_nx = ((match_cnt != 8'd0) && word_eq_prev) ? sat_inc(match_cnt, MATCH_N) : 8'd1;
      idle_nx  = 8'd0;
      cfg_nx   = sat_inc(cfg_run, MATCH_N);
      zero_nx  = (word_cur == 16'h0000) ? sat_inc(zero_run, ZERO_N) : 8'd0;
    end
  end

  // Autoneg next state, ack counter and TX-side control outputs
  always_comb begin
    state_nx            = state;
    ack_nx              = ack_cnt;
    latch_cfg           = 1'b0;
    sgmii_autoneg_start = 1'b0;
    sgmii_autoneg_ack   = 1'b0;
    sgmii_autoneg_done  = 1'b0;
    case (state)
      DISABLED: begin
        if (rx_sync) state_nx = ABILITY_DETECT;
      end
      ABILITY_DETECT: begin
        sgmii_autoneg_start = start_seen;
        if (word_done && (match_nx == MATCH_N) && (word_cur != 16'h0000)) begin
          latch_cfg = 1'b1;
          ack_nx    = 8'd0;
          state_nx  = ACK_DETECT;
        end
      end
      ACK_DETECT: begin
        sgmii_autoneg_start = 1'b1;
        sgmii_autoneg_ack   = 1'b1;
        if (word_done) begin
          if (!word_eq_partner) begin
            state_nx = ABILITY_DETECT;
          end else if (word_cur[14]) begin
            ack_nx = sat_inc(ack_cnt, MATCH_N);
            if (ack_nx == MATCH_N) state_nx = LINK_WAIT;
          end else begin
            ack_nx = 8'd0;
          end
        end
      end
      LINK_WAIT: begin
        sgmii_autoneg_start = 1'b1;
        sgmii_autoneg_ack   = 1'b1;
        if (word_done) begin
          ack_nx   = 8'd0;
          state_nx = ACK_DETECT;
        end else if (idle_done && (idle_nx == IDLE_N)) begin
          state_nx = LINK_OK;
        end
      end
      LINK_OK: begin
        sgmii_autoneg_done = 1'b1;
        if (word_done && ((cfg_nx == MATCH_N) || (zero_nx == ZERO_N)))
          state_nx = ABILITY_DETECT;
      end
      default: state_nx = DISABLED;
    endcase
    if (set_abort) ack_nx = 8'd0;
    if (!rx_sync) begin
      state_nx = DISABLED;
      ack_nx   = 8'd0;
    end
  end

  // Autoneg state register
  always_ff @(posedge clk_125mhz or posedge rst) begin
    if (rst) state <= DISABLED;
    else     state <= state_nx;
  end

  // Ordered-set position, captured word bytes, counters and sticky start flag
  always_ff @(posedge clk_125mhz or posedge rst) begin
    if (rst) begin
      pos        <= 2'd0;
      word_lo    <= 8'd0;
      prev_word  <= 16'd0;
      match_cnt  <= 8'd0;
      idle_cnt   <= 8'd0;
      cfg_run    <= 8'd0;
      zero_run   <= 8'd0;
      ack_cnt    <= 8'd0;
      start_seen <= 1'b0;
    end else if (!rx_sync) begin
      pos        <= 2'd0;
      match_cnt  <= 8'd0;
      idle_cnt   <= 8'd0;
      cfg_run    <= 8'd0;
      zero_run   <= 8'd0;
      ack_cnt    <= 8'd0;
      start_seen <= 1'b0;
    end else begin
      if (is_comma) begin
        pos <= 2'd1;
      end else if (set_abort) begin
        pos <= 2'd0;
      end else begin
        case (pos)
          2'd1: pos <= ((rx_byte == 8'hB5) || (rx_byte == 8'h42)) ? 2'd2 : 2'd0;
          2'd2: begin
            word_lo <= rx_byte;
            pos     <= 2'd3;
          end
          2'd3:    pos <= 2'd0;
          default: pos <= 2'd0;
        endcase
      end
      if (word_done) begin
        prev_word  <= word_cur;
        start_seen <= 1'b1;
      end
      match_cnt <= match_nx;
      idle_cnt  <= idle_nx;
      cfg_run   <= cfg_nx;
      zero_run  <= zero_nx;
      ack_cnt   <= ack_nx;
    end
  end

  // Latched partner config word and its one-cycle update strobe
  always_ff @(posedge clk_125mhz or posedge rst) begin
    if (rst) begin
      partner_config <= 16'h0000;
      config_valid   <= 1'b0;
    end else if (!rx_sync) begin
      partner_config <= 16'h0000;
      config_valid   <= 1'b0;
    end else begin
      config_valid <= latch_cfg;
      if (latch_cfg) partner_config <= word_cur;
    end
  end

  // GMII frame decoder, one registered stage behind the TBI byte
  always_ff @(posedge clk_125mhz or posedge rst) begin
    if (rst) begin
      in_frame <= 1'b0;
      rxd_p1   <= 8'h00;
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
    end else begin
      rxd_p1 <= 8'h00;
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
      if (!rx_sync || (state != LINK_OK)) begin
        in_frame <= 1'b0;
      end else if (!in_frame) begin
        if (rx_is_k && !rx_err && (rx_byte == K_S)) begin
          in_frame <= 1'b1;
          vld_p1   <= 1'b1;
          rxd_p1   <= 8'h55;
        end
      end else if (!rx_is_k) begin
        vld_p1 <= 1'b1;
        rxd_p1 <= rx_byte;
        err_p1 <= rx_err;
      end else if (rx_byte == K_T) begin
        in_frame <= 1'b0;
      end else if (rx_byte == K_E) begin
        vld_p1 <= 1'b1;
        err_p1 <= 1'b1;
        rxd_p1 <= K_E;
      end else begin
        vld_p1   <= 1'b1;
        err_p1   <= 1'b1;
        rxd_p1   <= rx_byte;
        in_frame <= 1'b0;
      end
    end
  end

endmodule
